pwm_capture: RTL and testbench

- 4-channel PWM input-capture peripheral on the memory-mapped peripheral bus, alongside the PWM generator.
- Measures period and high time, in clk cycles, of external PWM waveforms on pwm_in[3:0].
- Latches each complete measurement into software-readable registers, with valid and overflow status per channel.
- Firmware loops the generator's outputs back into this block for self-test.

---
 rtl/pwm_capture.sv | 183 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Four-channel PWM input capture: per-channel synchroniser + measurement FSM,
// with a memory-mapped CTRL/STATUS/PERIOD/HIGH register block.
`timescale 1ns/1ps

module pwm_capture_ch #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm,
    output logic             cap,
    output logic             ovf,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high
);
    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH_PH, LOW_PH} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync, prev, rise, fall, cnt_max;
    logic [CNT_W-1:0]       cnt, cnt_nx, hlat, hlat_nx;

    // Both edges see the same flop depth, so measured widths carry no offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            prev      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pwm};
            prev      <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign sync    = sync_pipe[SYNC_STAGES-1];
    assign rise    = sync & ~prev;
    assign fall    = ~sync & prev;
    assign cnt_max = &cnt;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hlat_nx  = hlat;
        cap      = 1'b0;
        ovf      = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx   = '0;
                    state_nx = WAIT_RISE;
                end
                WAIT_RISE: if (rise) begin
                    cnt_nx   = CNT_W'(1);
                    state_nx = HIGH_PH;
                end
                HIGH_PH: if (cnt_max) begin
                    ovf      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = WAIT_RISE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (fall) begin
                        hlat_nx  = cnt;
                        state_nx = LOW_PH;
                    end
                end
                LOW_PH: if (cnt_max) begin
                    ovf      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = WAIT_RISE;
                end else if (rise) begin
                    // Rising edge closes one period and opens the next.
                    cap      = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    state_nx = HIGH_PH;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hlat   <= '0;
            period <= '0;
            high   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hlat  <= hlat_nx;
            if (cap) begin
                period <= cnt;
                high   <= hlat;
            end
        end
    end
endmodule

module pwm_capture #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic [31:0] read_addr,
    output logic [31:0] read_data,
    input  logic [3:0]  pwm_in,
    output logic        irq_o
);
    localparam int          NUM_CH = 4;
    localparam logic [31:0] CTRL_A = 32'h6020_0000;
    localparam logic [31:0] STAT_A = 32'h6020_0004;
    localparam logic [31:0] PER_A  = 32'h6020_0010;

    logic [NUM_CH-1:0]            en, ie, valid, ovf_st, cap, ovf_hit, clr_v, clr_o;
    logic [NUM_CH-1:0][CNT_W-1:0] period, high;
    logic                         stat_we, wdata_unused;

    assign wdata_unused = ^write_data[31:12];

    function automatic logic [31:0] ext32(input logic [CNT_W-1:0] v);
        logic [CNT_W+31:0] w;
        w = {32'b0, v};
        return w[31:0];
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_capture_ch #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[g]),
            .pwm    (pwm_in[g]),
            .cap    (cap[g]),
            .ovf    (ovf_hit[g]),
            .period (period[g]),
            .high   (high[g])
        );
    end

    assign stat_we = we_i && (write_addr == STAT_A);
    assign clr_v   = stat_we ? write_data[3:0] : '0;
    assign clr_o   = stat_we ? write_data[7:4] : '0;

    // A capture in the same cycle as its W1C wins: set is ORed after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= '0;
            ie     <= '0;
            valid  <= '0;
            ovf_st <= '0;
        end else begin
            if (we_i && (write_addr == CTRL_A)) begin
                en <= write_data[3:0];
                ie <= write_data[11:8];
            end
            valid  <= (valid & ~clr_v) | cap;
            ovf_st <= (ovf_st & ~clr_o) | ovf_hit;
        end
    end

    always_comb begin
        read_data = '0;
        if (read_addr == CTRL_A)      read_data = {20'b0, ie, 4'b0, en};
        else if (read_addr == STAT_A) read_data = {24'b0, ovf_st, valid};
        for (int n = 0; n < NUM_CH; n++) begin
            if (read_addr == PER_A + 32'(8 * n))          read_data = ext32(period[n]);
            if (read_addr == PER_A + 32'(8 * n) + 32'd4)  read_data = ext32(high[n]);
        end
    end

    assign irq_o = |(valid & ie);
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: 32-bit and 8-bit counter builds on shared stimulus,
// checked every cycle against a timestamp-based model plus literal spot checks.
`timescale 1ns/1ps

module tb_pwm_capture;
    localparam int          S      = 2;
    localparam logic [31:0] A_CTRL = 32'h6020_0000;
    localparam logic [31:0] A_STAT = 32'h6020_0004;
    localparam logic [31:0] A_PER  = 32'h6020_0010;

    logic        clk = 1'b0;
    logic        rst, we_i;
    logic [31:0] write_addr, write_data, read_addr;
    logic [3:0]  pwm_in = '0;
    logic [31:0] rd32, rd8;
    logic        irq32, irq8;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(32), .SYNC_STAGES(S)) dut32 (
        .clk(clk), .rst(rst), .we_i(we_i), .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(rd32), .pwm_in(pwm_in), .irq_o(irq32));
    pwm_capture #(.CNT_W(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .rst(rst), .we_i(we_i), .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(rd8), .pwm_in(pwm_in), .irq_o(irq8));

    int total = 0, bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- waveform generator: high gen_hi, low gen_lo, from gen_t0
    longint cyc = 0;
    int     gen_hi[4] = '{0, 0, 0, 0};
    int     gen_lo[4] = '{1, 1, 1, 1};
    longint gen_t0[4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        logic [3:0] nv;
        #2;
        for (int n = 0; n < 4; n++)
            nv[n] = ((cyc - gen_t0[n]) % longint'(gen_hi[n] + gen_lo[n])) < longint'(gen_hi[n]);
        pwm_in = nv;
    end

    // ---------------- model: pin history + timestamps of the last rise/fall
    longint     maxc[2] = '{64'hFFFF_FFFF, 64'hFF};
    logic [11:0] m_ctrl;
    logic [7:0]  m_stat[2];
    longint      m_per[2][4], m_hi[2][4], m_tr[2][4], m_tf[2][4];
    bit          m_hr[2][4], m_hf[2][4], m_enp[4];
    logic [S:0]  hist[4];
    bit          mdl_ok = 0;

    always @(posedge clk) begin
        logic [7:0] setv[2];
        logic [7:0] clr;
        bit         rise, fall, en;
        longint     el;
        if (rst) begin
            m_ctrl = '0;
            for (int i = 0; i < 2; i++) begin
                m_stat[i] = '0;
                for (int n = 0; n < 4; n++) begin
                    m_per[i][n] = 0; m_hi[i][n] = 0; m_hr[i][n] = 0; m_hf[i][n] = 0;
                end
            end
            for (int n = 0; n < 4; n++) begin m_enp[n] = 0; hist[n] = '0; end
            mdl_ok = 1;
        end else begin
            setv[0] = '0; setv[1] = '0;
            for (int n = 0; n < 4; n++) begin
                rise = hist[n][S-1] && !hist[n][S];
                fall = !hist[n][S-1] && hist[n][S];
                en   = m_ctrl[n];
                for (int i = 0; i < 2; i++) begin
                    if (!en || !m_enp[n]) begin
                        m_hr[i][n] = 0; m_hf[i][n] = 0;
                    end else if (m_hr[i][n]) begin
                        el = cyc - m_tr[i][n];
                        if (el == maxc[i]) begin
                            setv[i][4+n] = 1'b1; m_hr[i][n] = 0;
                        end else if (m_hf[i][n] && rise) begin
                            setv[i][n] = 1'b1;
                            m_per[i][n] = el;
                            m_hi[i][n]  = m_tf[i][n] - m_tr[i][n];
                            m_tr[i][n]  = cyc; m_hf[i][n] = 0;
                        end else if (!m_hf[i][n] && fall) begin
                            m_tf[i][n] = cyc; m_hf[i][n] = 1;
                        end
                    end else if (rise) begin
                        m_hr[i][n] = 1; m_hf[i][n] = 0; m_tr[i][n] = cyc;
                    end
                end
                m_enp[n] = en;
                hist[n]  = {hist[n][S-1:0], pwm_in[n]};
            end
            clr = (we_i && write_addr == A_STAT) ? write_data[7:0] : 8'h00;
            for (int i = 0; i < 2; i++) m_stat[i] = (m_stat[i] & ~clr) | setv[i];
            if (we_i && write_addr == A_CTRL) m_ctrl = write_data[11:0] & 12'hF0F;
        end
        cyc++;
    end

    function automatic logic [31:0] mread(input int i, input logic [31:0] a);
        logic [31:0] r = '0;
        if (a == A_CTRL) r = {20'b0, m_ctrl};
        if (a == A_STAT) r = {24'b0, m_stat[i]};
        for (int n = 0; n < 4; n++) begin
            if (a == A_PER + 32'(8 * n))         r = m_per[i][n][31:0];
            if (a == A_PER + 32'(8 * n) + 32'd4) r = m_hi[i][n][31:0];
        end
        return r;
    endfunction

    always @(negedge clk) if (mdl_ok) begin
        chk("rd32", rd32, mread(0, read_addr));
        chk("rd8", rd8, mread(1, read_addr));
        chk("irq32", irq32, |(m_stat[0][3:0] & m_ctrl[11:8]));
        chk("irq8", irq8, |(m_stat[1][3:0] & m_ctrl[11:8]));
    end

    // ---------------- stimulus helpers
    logic [31:0] raddr[13];
    int          ridx = 0;

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            read_addr = raddr[ridx];
            ridx = (ridx + 1) % 13;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        we_i = 1'b1; write_addr = a; write_data = d;
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    task automatic rdc(input string nm, input logic [31:0] a, input logic [31:0] e32, input logic [31:0] e8);
        @(posedge clk); #1;
        read_addr = a;
        #1;
        chk({nm, "/32"}, rd32, e32);
        chk({nm, "/8"}, rd8, e8);
    endtask

    task automatic irqc(input string nm, input logic e);
        @(posedge clk); #2;
        chk({nm, "/32"}, irq32, e);
        chk({nm, "/8"}, irq8, e);
    endtask

    task automatic wave(input int n, input int hi, input int lo);
        gen_hi[n] = hi; gen_lo[n] = lo; gen_t0[n] = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic r1a, r1b, r2a, r2b;
        rst = 1'b1; we_i = 1'b0; write_addr = '0; write_data = '0; read_addr = '0;
        raddr[0] = A_CTRL; raddr[1] = A_STAT; raddr[2] = 32'h6020_0008;
        for (int k = 0; k < 8; k++) raddr[3+k] = A_PER + 32'(4 * k);
        raddr[11] = 32'h6020_000C; raddr[12] = 32'h6020_0030;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        for (int k = 0; k < 13; k++) rdc("reset_rd", raddr[k], 0, 0);
        irqc("reset_irq", 1'b0);

        // ch0 30/70 with interrupt
        wr(A_CTRL, 32'h101);
        wave(0, 30, 70);
        tick(250);
        rdc("ch0_per", A_PER, 100, 100);
        rdc("ch0_high", A_PER + 4, 30, 30);
        rdc("ch0_stat", A_STAT, 1, 1);
        irqc("ch0_irq", 1'b1);
        wave(0, 0, 1);
        wr(A_STAT, 32'h1);
        rdc("w1c_stat", A_STAT, 0, 0);
        irqc("w1c_irq", 1'b0);
        wr(A_CTRL, 32'h0);

        // all four channels
        wave(0, 10, 10); wave(1, 1, 3); wave(2, 50, 150); wave(3, 5, 5);
        wr(A_CTRL, 32'h00F);
        tick(550);
        rdc("per0", A_PER + 0,  20, 20);   rdc("high0", A_PER + 4,  10, 10);
        rdc("per1", A_PER + 8,  4, 4);     rdc("high1", A_PER + 12, 1, 1);
        rdc("per2", A_PER + 16, 200, 200); rdc("high2", A_PER + 20, 50, 50);
        rdc("per3", A_PER + 24, 10, 10);   rdc("high3", A_PER + 28, 5, 5);
        rdc("stat_all", A_STAT, 32'h0F, 32'h0F);
        wave(1, 1, 1);
        tick(20);
        rdc("per1_fast", A_PER + 8, 2, 2);
        rdc("high1_fast", A_PER + 12, 1, 1);

        // ch2 stuck high after a rise: only the 8-bit build overflows
        wr(A_CTRL, 32'h00B);
        wave(2, 0, 1);
        tick(5);
        wr(A_CTRL, 32'h00F);
        tick(5);
        wave(2, 1, 0);
        tick(300);
        rdc("ovf_stat", A_STAT, 32'h0F, 32'h4F);
        rdc("ovf_per2", A_PER + 16, 200, 200);
        wave(2, 20, 20);
        tick(250);
        rdc("post_ovf_per2", A_PER + 16, 40, 40);
        rdc("post_ovf_high2", A_PER + 20, 20, 20);

        // disable ch0 mid-period, re-enable: old results kept until two new rises
        wr(A_CTRL, 32'h00E);
        wave(0, 4, 12);
        tick(7);
        wr(A_CTRL, 32'h00F);
        tick(10);
        rdc("retain_per0", A_PER, 20, 20);
        rdc("retain_high0", A_PER + 4, 10, 10);
        tick(60);
        rdc("new_per0", A_PER, 16, 16);
        rdc("new_high0", A_PER + 4, 4, 4);

        // W1C of VALID0 held over two edges; exactly one of them is a capture edge
        wave(0, 1, 1);
        tick(10);
        @(posedge clk); #1;
        we_i = 1'b1; write_addr = A_STAT; write_data = 32'h1; read_addr = A_STAT;
        @(posedge clk); #2;
        r1a = rd32[0]; r1b = rd8[0];
        @(posedge clk); #2;
        r2a = rd32[0]; r2b = rd8[0];
        we_i = 1'b0;
        chk("set_wins/32", longint'(r1a ^ r2a), 1);
        chk("set_wins/8", longint'(r1b ^ r2b), 1);

        // reset mid-measurement
        tick(3);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 13; k++) rdc("rst2_rd", raddr[k], 0, 0);
        irqc("rst2_irq", 1'b0);
        wr(A_CTRL, 32'h001);
        rdc("no_stale_per0", A_PER, 0, 0);
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
